slice_header_uv_sequencer: RTL and testbench
============================================

Name: slice_header_uv_sequencer

Overview:
- Sequences the fixed-length u(v) slice-header fields frame_num and pic_order_cnt_lsb out of the 16-bit bitstream window.
- Per field: computes the field length from the SPS log2 parameters, waits for the window to hold valid bits, then extracts and latches the value.
- Issues a one-cycle consume request so the bitstream buffer advances by the field length.
- Sits between the slice-header parser FSM (start/done) and the bitstream buffer (ready/consume).

Parameters:
- MAX_LEN, 16, largest legal field length in bits; any length above this raises the error path.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begins a field sequence when in IDLE
- abort  input  1  pulse; returns to IDLE from any state
- pic_order_cnt_type  input  2  SPS value; the POC field is parsed only when this is 0
- log2_max_frame_num_minus4  input  4  SPS value
- log2_max_pic_order_cnt_lsb_minus4  input  4  SPS value
- BitStream_buffer_output  input  16  bitstream window; bit 15 is the next bit
- buffer_ready  input  1  window holds at least 16 valid bits
- consume_req  output  1  pulse; the buffer shifts by consume_len on this cycle
- consume_len  output  5  number of bits to consume; valid with consume_req, 0 otherwise
- busy  output  1  high whenever the FSM is not in IDLE
- done  output  1  one-cycle pulse at the end of a sequence, normal or error
- error  output  1  set on an illegal length; sticky until the next accepted start
- frame_num  output  16  latched value, zero-extended
- frame_num_valid  output  1  high once frame_num has been latched in this sequence
- pic_order_cnt_lsb  output  16  latched value, zero-extended
- poc_lsb_valid  output  1  high once pic_order_cnt_lsb has been latched in this sequence

Behaviour:
- Reset: every output is 0; FSM is in IDLE.
- States: IDLE, FN, FN_WAIT, POC, POC_WAIT, DONE, ERR.
- IDLE, start=1 and abort=0:
  - Register pic_order_cnt_type and both log2 values; later changes to these inputs are ignored until the next start.
  - Clear error, both valid flags and both values.
  - Go to FN.
- Length rules: len_fn = log2_max_frame_num_minus4 + 4 and len_poc = log2_max_pic_order_cnt_lsb_minus4 + 4, computed at 5-bit width. A length greater than MAX_LEN (i.e. minus4 > 12) is illegal.
- Extraction: value = BitStream_buffer_output >> (16 - len), zero-extended to 16 bits.
- FN:
  - Illegal len_fn: go to ERR; no consume.
  - Otherwise stall while buffer_ready=0.
  - When buffer_ready=1, in that same cycle: latch frame_num, set frame_num_valid, drive consume_req=1 with consume_len=len_fn. Next state FN_WAIT.
- FN_WAIT: one idle cycle so the buffer window can update. Then go to POC if the registered pic_order_cnt_type == 0, else DONE.
- POC / POC_WAIT: same as FN / FN_WAIT using len_poc, pic_order_cnt_lsb and poc_lsb_valid. POC_WAIT always goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ERR: done=1 and error=1 for one cycle, then IDLE. error stays high in IDLE.
- consume_req: registered, exactly one cycle long, never asserted in two consecutive cycles.
- Latency, buffer_ready held high:
  - POC type 0: start to done is 6 cycles.
  - Otherwise: start to done is 4 cycles.
- Abort:
  - Takes priority over every other event, including a simultaneous start or buffer_ready.
  - Next state is IDLE; no done pulse; consume_req is forced low that cycle; valid flags are cleared; error is unchanged.
- start while busy=1: ignored.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs 0. Any consume_req in flight is dropped.

Test Plan:
- Case 1, full sequence: minus4 values 0/2, poc_type 0, window 0xA5F0, buffer_ready high, then start.
  - consume_len 4 is issued with frame_num=0x000A.
  - The bench shifts the window to 0x5F00; consume_len 6 is issued with pic_order_cnt_lsb=0x0017.
  - done pulses 6 cycles after start; error=0.
- Case 2, POC skipped: poc_type 1, log2_max_frame_num_minus4=12, window 0xFFFF.
  - frame_num=0xFFFF with consume_len 16.
  - poc_lsb_valid stays 0; done pulses 4 cycles after start.
- Case 3, stall: buffer_ready low for 5 cycles after entering FN.
  - consume_req stays 0 throughout the stall.
  - consume_req fires in the cycle buffer_ready rises; done is delayed by exactly 5 cycles.
- Case 4, illegal length: log2_max_frame_num_minus4=13.
  - No consume_req is issued; done and error pulse together.
  - error remains high until the next start.
- Case 5, abort in POC with buffer_ready=1 in the same cycle:
  - No consume_req; FSM returns to IDLE; done never asserts.
  - frame_num_valid and poc_lsb_valid read 0.
- Case 6, reset and start rules:
  - reset_n pulsed low mid-FN_WAIT: all outputs read 0 asynchronously.
  - A start issued while busy is ignored; a start issued in IDLE after reset completes normally.

Source files
------------

// File: rtl/slice_header_uv_sequencer.sv
// Sequences the fixed-length u(v) slice-header fields frame_num and pic_order_cnt_lsb
// out of a 16-bit bitstream window, issuing one registered consume request per field.
module slice_header_uv_sequencer #(
    parameter int unsigned MAX_LEN = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  pic_order_cnt_type,
    input  logic [3:0]  log2_max_frame_num_minus4,
    input  logic [3:0]  log2_max_pic_order_cnt_lsb_minus4,
    input  logic [15:0] BitStream_buffer_output,
    input  logic        buffer_ready,
    output logic        consume_req,
    output logic [4:0]  consume_len,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] frame_num,
    output logic        frame_num_valid,
    output logic [15:0] pic_order_cnt_lsb,
    output logic        poc_lsb_valid
);

    typedef enum logic [2:0] {
        StIdle, StFn, StFnWait, StPoc, StPocWait, StDone, StErr
    } state_e;

    localparam logic [4:0] MaxLenW = 5'(MAX_LEN);

    state_e      state_q, state_d;
    logic [1:0]  poc_type_q;
    logic [3:0]  fn_m4_q, poc_m4_q;
    logic [4:0]  len_fn, len_poc, cur_len;
    logic        fn_ok, poc_ok, accept;
    logic [15:0] field_val;

    logic        consume_req_q, consume_req_d;
    logic [4:0]  consume_len_q, consume_len_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] frame_num_q, frame_num_d;
    logic        fn_valid_q, fn_valid_d;
    logic [15:0] poc_lsb_q, poc_lsb_d;
    logic        poc_valid_q, poc_valid_d;

    assign len_fn    = {1'b0, fn_m4_q} + 5'd4;
    assign len_poc   = {1'b0, poc_m4_q} + 5'd4;
    assign fn_ok     = (len_fn <= MaxLenW);
    assign poc_ok    = (len_poc <= MaxLenW);
    assign accept    = (state_q == StIdle) && start && !abort;
    assign cur_len   = (state_q == StPoc) ? len_poc : len_fn;
    // Bit 15 is the next stream bit, so the field sits in the top cur_len bits.
    assign field_val = BitStream_buffer_output >> (5'd16 - cur_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            poc_type_q <= 2'd0;
            fn_m4_q    <= 4'd0;
            poc_m4_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                poc_type_q <= pic_order_cnt_type;
                fn_m4_q    <= log2_max_frame_num_minus4;
                poc_m4_q   <= log2_max_pic_order_cnt_lsb_minus4;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (start) state_d = StFn;
                StFn:      if (!fn_ok) state_d = StErr;
                           else if (buffer_ready) state_d = StFnWait;
                StFnWait:  state_d = (poc_type_q == 2'd0) ? StPoc : StDone;
                StPoc:     if (!poc_ok) state_d = StErr;
                           else if (buffer_ready) state_d = StPocWait;
                StPocWait: state_d = StDone;
                StDone:    state_d = StIdle;
                StErr:     state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        consume_req_d = 1'b0;
        consume_len_d = 5'd0;
        done_d        = 1'b0;
        error_d       = error_q;
        frame_num_d   = frame_num_q;
        fn_valid_d    = fn_valid_q;
        poc_lsb_d     = poc_lsb_q;
        poc_valid_d   = poc_valid_q;
        if (abort) begin
            fn_valid_d  = 1'b0;
            poc_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        error_d     = 1'b0;
                        fn_valid_d  = 1'b0;
                        poc_valid_d = 1'b0;
                        frame_num_d = 16'd0;
                        poc_lsb_d   = 16'd0;
                    end
                end
                StFn: begin
                    if (fn_ok && buffer_ready) begin
                        consume_req_d = 1'b1;
                        consume_len_d = len_fn;
                        frame_num_d   = field_val;
                        fn_valid_d    = 1'b1;
                    end
                end
                StPoc: begin
                    if (poc_ok && buffer_ready) begin
                        consume_req_d = 1'b1;
                        consume_len_d = len_poc;
                        poc_lsb_d     = field_val;
                        poc_valid_d   = 1'b1;
                    end
                end
                StDone: done_d = 1'b1;
                StErr: begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            consume_req_q <= 1'b0;
            consume_len_q <= 5'd0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            frame_num_q   <= 16'd0;
            fn_valid_q    <= 1'b0;
            poc_lsb_q     <= 16'd0;
            poc_valid_q   <= 1'b0;
        end else begin
            consume_req_q <= consume_req_d;
            consume_len_q <= consume_len_d;
            done_q        <= done_d;
            error_q       <= error_d;
            frame_num_q   <= frame_num_d;
            fn_valid_q    <= fn_valid_d;
            poc_lsb_q     <= poc_lsb_d;
            poc_valid_q   <= poc_valid_d;
        end
    end

    assign busy              = (state_q != StIdle);
    assign consume_req       = consume_req_q;
    assign consume_len       = consume_len_q;
    assign done              = done_q;
    assign error             = error_q;
    assign frame_num         = frame_num_q;
    assign frame_num_valid   = fn_valid_q;
    assign pic_order_cnt_lsb = poc_lsb_q;
    assign poc_lsb_valid     = poc_valid_q;

endmodule

// File: tb/tb_slice_header_uv_sequencer.sv
// Scoreboard bench for slice_header_uv_sequencer: a bit-stream model feeds the window and
// a field-level reference model predicts every consume and done event.
module tb_slice_header_uv_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  poc_type = 2'd0;
    logic [3:0]  fn_m4 = 4'd0;
    logic [3:0]  poc_m4 = 4'd0;
    logic        buffer_ready = 1'b0;
    logic [63:0] stream = 64'd0;
    logic [15:0] window;
    logic        consume_req, busy, done, error, fn_valid, poc_valid;
    logic [4:0]  consume_len;
    logic [15:0] frame_num, poc_lsb;

    assign window = stream[63:48];

    slice_header_uv_sequencer #(.MAX_LEN(16)) dut (
        .clk                               (clk),
        .reset_n                           (reset_n),
        .start                             (start),
        .abort                             (abort),
        .pic_order_cnt_type                (poc_type),
        .log2_max_frame_num_minus4         (fn_m4),
        .log2_max_pic_order_cnt_lsb_minus4 (poc_m4),
        .BitStream_buffer_output           (window),
        .buffer_ready                      (buffer_ready),
        .consume_req                       (consume_req),
        .consume_len                       (consume_len),
        .busy                              (busy),
        .done                              (done),
        .error                             (error),
        .frame_num                         (frame_num),
        .frame_num_valid                   (fn_valid),
        .pic_order_cnt_lsb                 (poc_lsb),
        .poc_lsb_valid                     (poc_valid)
    );

    always #5 clk = ~clk;

    // kind: 0 = frame_num consume, 1 = POC consume, 2 = done
    typedef struct {
        int kind;
        int len;
        int val;
        int err;
        int fnv;
        int pocv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    bit   prev_cons = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_cons = 1'b0;
        end else begin
            if (consume_req) begin
                chk("consume_gap", 32'(prev_cons), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_consume", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("consume_expected", 32'(mon_e.kind != 2), 32'd1);
                    chk("consume_len", 32'(consume_len), 32'(mon_e.len));
                    if (mon_e.kind == 0) begin
                        chk("frame_num", 32'(frame_num), 32'(mon_e.val));
                        chk("frame_num_valid", 32'(fn_valid), 32'd1);
                    end else begin
                        chk("pic_order_cnt_lsb", 32'(poc_lsb), 32'(mon_e.val));
                        chk("poc_lsb_valid", 32'(poc_valid), 32'd1);
                    end
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_expected", 32'(mon_e.kind == 2), 32'd1);
                    chk("error_at_done", 32'(error), 32'(mon_e.err));
                    chk("fn_valid_at_done", 32'(fn_valid), 32'(mon_e.fnv));
                    chk("poc_valid_at_done", 32'(poc_valid), 32'(mon_e.pocv));
                end
            end
            prev_cons = consume_req;
        end
    end

    task automatic push(input int k, input int l, input int v, input int e, input int f,
                        input int p);
        exp_t x;
        x.kind = k; x.len = l; x.val = v; x.err = e; x.fnv = f; x.pocv = p;
        exp_q.push_back(x);
    endtask

    // Field-level model: the fields are simply the next bits of the stream, in order.
    task automatic push_model(input logic [1:0] t, input logic [3:0] a, input logic [3:0] b,
                              input logic [63:0] s);
        int lf = int'(a) + 4;
        int lp = int'(b) + 4;
        logic [63:0] r = s;
        if (lf > 16) begin
            push(2, 0, 0, 1, 0, 0);
            return;
        end
        push(0, lf, int'(r >> (64 - lf)), 0, 0, 0);
        r = r << lf;
        if (t != 2'd0) begin
            push(2, 0, 0, 0, 1, 0);
        end else if (lp > 16) begin
            push(2, 0, 0, 1, 1, 0);
        end else begin
            push(1, lp, int'(r >> (64 - lp)), 0, 0, 0);
            push(2, 0, 0, 0, 1, 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (consume_req) stream = stream << consume_len;
        cyc++;
    endtask

    task automatic do_start(input logic [1:0] t, input logic [3:0] a, input logic [3:0] b);
        poc_type = t;
        fn_m4 = a;
        poc_m4 = b;
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit rnd, output int lat);
        int n = 0;
        while (!done && n < bound) begin
            if (rnd) begin
                buffer_ready = ($urandom % 3) != 0;
                poc_type = 2'($urandom);
                fn_m4 = 4'($urandom);
                poc_m4 = 4'($urandom);
            end
            step();
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        lat = cyc - start_cyc;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outputs_zero"},
            {consume_req, consume_len, busy, done, error, fn_valid, poc_valid}, 32'd0);
        chk({tag, "_values_zero"}, {frame_num, poc_lsb}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bit saw;
        logic [1:0] t;
        logic [3:0] a, b;
        int e;

        #3;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Case 1: full sequence with POC
        stream = {16'hA5F0, 48'd0};
        buffer_ready = 1'b1;
        push_model(2'd0, 4'd0, 4'd2, stream);
        do_start(2'd0, 4'd0, 4'd2);
        wait_done(50, 1'b0, lat);
        chk("case1_latency", 32'(lat), 32'd6);

        // Case 2: POC skipped, 16-bit frame_num
        step();
        stream = {16'hFFFF, 48'd0};
        push_model(2'd1, 4'd12, 4'd0, stream);
        do_start(2'd1, 4'd12, 4'd0);
        wait_done(50, 1'b0, lat);
        chk("case2_latency", 32'(lat), 32'd4);
        chk("case2_poc_valid", 32'(poc_valid), 32'd0);

        // Case 3: stall with buffer_ready low for 5 FN cycles
        step();
        stream = {16'h3C5A, 48'h123456789ABC};
        buffer_ready = 1'b0;
        push_model(2'd1, 4'd3, 4'd0, stream);
        do_start(2'd1, 4'd3, 4'd0);
        for (int i = 0; i < 5; i++) begin
            chk("case3_stall_no_consume", 32'(consume_req), 32'd0);
            step();
        end
        chk("case3_stall_no_consume", 32'(consume_req), 32'd0);
        buffer_ready = 1'b1;
        step();
        chk("case3_consume_after_ready", 32'(consume_req), 32'd1);
        wait_done(50, 1'b0, lat);
        chk("case3_latency", 32'(lat), 32'd9);

        // Case 4: illegal frame_num length
        step();
        stream = {$urandom, $urandom};
        push_model(2'd0, 4'd13, 4'd1, stream);
        do_start(2'd0, 4'd13, 4'd1);
        wait_done(50, 1'b0, lat);
        chk("case4_error_with_done", 32'(error), 32'd1);
        for (int i = 0; i < 3; i++) step();
        chk("case4_error_sticky", 32'(error), 32'd1);
        chk("case4_idle", 32'(busy), 32'd0);

        // Case 5: abort in POC with buffer_ready high
        stream = {16'h8421, 48'd0};
        push(0, 5, int'(stream >> 59), 0, 0, 0);
        do_start(2'd0, 4'd1, 4'd2);
        chk("case5_error_cleared", 32'(error), 32'd0);
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("case5_no_consume", 32'(consume_req), 32'd0);
        chk("case5_idle", 32'(busy), 32'd0);
        chk("case5_valids", {fn_valid, poc_valid}, 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) saw = 1'b1;
        end
        chk("case5_no_done", 32'(saw), 32'd0);

        // Case 6: reset in FN_WAIT, then start-while-busy ignored
        stream = {16'hF00F, 48'd0};
        push_model(2'd0, 4'd0, 4'd0, stream);
        do_start(2'd0, 4'd0, 4'd0);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("case6_async_reset");
        exp_q.delete();
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        step();
        stream = {16'h9E37, 48'h79B97F4A7C15};
        push_model(2'd0, 4'd2, 4'd3, stream);
        do_start(2'd0, 4'd2, 4'd3);
        step();
        step();
        chk("case6_busy", 32'(busy), 32'd1);
        poc_type = 2'd3;
        fn_m4 = 4'd15;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(50, 1'b0, lat);
        chk("case6_latency", 32'(lat), 32'd6);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (busy) saw = 1'b1;
        end
        chk("case6_busy_start_ignored", 32'(saw), 32'd0);

        // Randomised sequences; SPS inputs and buffer_ready wander while busy
        for (int n = 0; n < 40; n++) begin
            t = 2'($urandom);
            a = ($urandom % 8 == 0) ? 4'(13 + $urandom % 3) : 4'($urandom % 13);
            b = ($urandom % 8 == 0) ? 4'(13 + $urandom % 3) : 4'($urandom % 13);
            e = (a > 4'd12 || (t == 2'd0 && b > 4'd12)) ? 1 : 0;
            stream = {$urandom, $urandom};
            buffer_ready = ($urandom % 2) != 0;
            push_model(t, a, b, stream);
            do_start(t, a, b);
            wait_done(200, 1'b1, lat);
            step();
            step();
            chk("rand_error_sticky", 32'(error), 32'(e));
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
